// File: rtl/gm64_bist_pkg.sv
// Shared types and constants for the PSRAM self-test engine:
// FSM state encoding, data-pattern selectors and LFSR configuration.
package gm64_bist_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WR_ISSUE,
    ST_WR_WAIT,
    ST_RD_ISSUE,
    ST_RD_WAIT,
    ST_CHECK,
    ST_DONE,
    ST_TMO
  } BistState;

  localparam logic [1:0] PAT_CONST = 2'd0;
  localparam logic [1:0] PAT_ADDR  = 2'd1;
  localparam logic [1:0] PAT_NADDR = 2'd2;
  localparam logic [1:0] PAT_LFSR  = 2'd3;

  localparam logic [7:0] LFSR_SEED = 8'hA5;
  // Right-shifting Galois form of x^8+x^6+x^5+x^4+1
  localparam logic [7:0] LFSR_TAPS = 8'hB8;

  function automatic logic [7:0] lfsr_next(input logic [7:0] v);
    return v[0] ? ((v >> 1) ^ LFSR_TAPS) : (v >> 1);
  endfunction

endpackage

// File: rtl/bist_pattern_gen.sv
// Expected-data generator: owns the LFSR and selects the byte for the
// current address, so write data and compare data come from one place.
module bist_pattern_gen
  import gm64_bist_pkg::*;
#(
  parameter logic [7:0] CONST_PAT = 8'hCA
) (
  input  logic       clkSys,
  input  logic       rst,
  input  logic       seed,
  input  logic       advance,
  input  logic [1:0] mode,
  input  logic [7:0] addr_lo,
  output logic [7:0] pat_byte
);

  logic [7:0] lfsr;

  always_ff @(posedge clkSys or negedge rst) begin
    if (!rst) begin
      lfsr <= LFSR_SEED;
    end else if (seed) begin
      lfsr <= LFSR_SEED;
    end else if (advance) begin
      lfsr <= lfsr_next(lfsr);
    end
  end

  always_comb begin
    pat_byte = CONST_PAT;
    case (mode)
      PAT_CONST: pat_byte = CONST_PAT;
      PAT_ADDR:  pat_byte = addr_lo;
      PAT_NADDR: pat_byte = ~addr_lo;
      PAT_LFSR:  pat_byte = lfsr;
      default:   pat_byte = CONST_PAT;
    endcase
  end

endmodule

// File: rtl/psram_bist.sv
// PSRAM self-test: full write pass over the address window, then a
// read/compare pass, reporting pass/fail, error count, first bad address.
//
// Handshake with the controller: a request is one cycle of o_cs=0 with
// o_write/o_address/o_dataToWrite valid, issued only when i_busy=0. A write
// completes when i_busy is low again (the cycle of the strobe is ignored);
// a read completes when i_dataReady=1 and i_busy=0 in the same cycle.
module psram_bist
  import gm64_bist_pkg::*;
#(
  parameter int                 ADDR_W     = 24,
  parameter logic [ADDR_W-1:0]  START_ADDR = 24'h000000,
  parameter int                 LENGTH     = 256,
  parameter logic [7:0]         CONST_PAT  = 8'hCA,
  parameter int                 ERR_W      = 16,
  parameter int                 TIMEOUT    = 1023
) (
  input  logic              clkSys,
  input  logic              rst,
  input  logic              i_start,
  input  logic [1:0]        i_pattern,
  input  logic              i_stopOnErr,
  input  logic              i_bank,
  output logic              o_cs,
  output logic              o_write,
  output logic [ADDR_W-1:0] o_address,
  output logic              o_bank,
  output logic [7:0]        o_dataToWrite,
  input  logic [7:0]        i_dataRead,
  input  logic              i_busy,
  input  logic              i_dataReady,
  output logic              o_running,
  output logic              o_done,
  output logic              o_pass,
  output logic              o_timeout,
  output logic [ERR_W-1:0]  o_errCount,
  output logic [ADDR_W-1:0] o_firstFailAddr,
  output BistState          o_state
);

  localparam logic [ADDR_W-1:0] LAST_ADDR = START_ADDR + ADDR_W'(LENGTH - 1);
  localparam int                TMO_W     = $clog2(TIMEOUT + 1);
  localparam logic [TMO_W-1:0]  TMO_LAST  = TMO_W'(TIMEOUT - 1);

  BistState          state, state_nxt;
  logic [ADDR_W-1:0] addr;
  logic [1:0]        mode_q;
  logic              stop_q;
  logic [7:0]        rd_byte;
  logic [TMO_W-1:0]  tmo_cnt;
  logic [7:0]        pat_byte;

  logic do_start, strobe, seed, advance, capture, is_last, mismatch, tmo_hit;

  bist_pattern_gen #(.CONST_PAT(CONST_PAT)) u_pat (
    .clkSys  (clkSys),
    .rst     (rst),
    .seed    (seed),
    .advance (advance),
    .mode    (mode_q),
    .addr_lo (addr[7:0]),
    .pat_byte(pat_byte)
  );

  always_ff @(posedge clkSys or negedge rst) begin
    if (!rst) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    do_start  = 1'b0;
    strobe    = 1'b0;
    seed      = 1'b0;
    advance   = 1'b0;
    capture   = 1'b0;
    is_last   = (addr == LAST_ADDR);
    mismatch  = (rd_byte != pat_byte);
    tmo_hit   = (tmo_cnt == TMO_LAST);
    case (state)
      ST_IDLE, ST_DONE, ST_TMO: begin
        if (i_start) begin
          do_start  = 1'b1;
          seed      = 1'b1;
          state_nxt = ST_WR_ISSUE;
        end
      end
      ST_WR_ISSUE: begin
        if (!i_busy) begin
          strobe    = 1'b1;
          state_nxt = ST_WR_WAIT;
        end
      end
      ST_WR_WAIT: begin
        // tmo_cnt==0 marks the strobe cycle, where i_busy is not yet meaningful
        if (tmo_cnt != '0 && !i_busy) begin
          if (is_last) begin
            seed      = 1'b1;
            state_nxt = ST_RD_ISSUE;
          end else begin
            advance   = 1'b1;
            state_nxt = ST_WR_ISSUE;
          end
        end else if (tmo_hit) begin
          state_nxt = ST_TMO;
        end
      end
      ST_RD_ISSUE: begin
        if (!i_busy) begin
          strobe    = 1'b1;
          state_nxt = ST_RD_WAIT;
        end
      end
      ST_RD_WAIT: begin
        if (i_dataReady && !i_busy) begin
          capture   = 1'b1;
          state_nxt = ST_CHECK;
        end else if (tmo_hit) begin
          state_nxt = ST_TMO;
        end
      end
      ST_CHECK: begin
        if ((mismatch && stop_q) || is_last) begin
          state_nxt = ST_DONE;
        end else begin
          advance   = 1'b1;
          state_nxt = ST_RD_ISSUE;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clkSys or negedge rst) begin
    if (!rst) begin
      o_cs            <= 1'b1;
      o_write         <= 1'b0;
      o_address       <= '0;
      o_bank          <= 1'b0;
      o_dataToWrite   <= '0;
      o_done          <= 1'b0;
      o_pass          <= 1'b0;
      o_timeout       <= 1'b0;
      o_errCount      <= '0;
      o_firstFailAddr <= '0;
      addr            <= '0;
      mode_q          <= PAT_CONST;
      stop_q          <= 1'b0;
      rd_byte         <= '0;
      tmo_cnt         <= '0;
    end else begin
      o_cs <= ~strobe;
      if (strobe) begin
        o_write       <= (state == ST_WR_ISSUE);
        o_address     <= addr;
        o_dataToWrite <= pat_byte;
      end
      if (strobe) begin
        tmo_cnt <= '0;
      end else if (state == ST_WR_WAIT || state == ST_RD_WAIT) begin
        tmo_cnt <= tmo_cnt + TMO_W'(1);
      end
      if (seed) begin
        addr <= START_ADDR;
      end else if (advance) begin
        addr <= addr + ADDR_W'(1);
      end
      if (do_start) begin
        mode_q          <= i_pattern;
        stop_q          <= i_stopOnErr;
        o_bank          <= i_bank;
        o_errCount      <= '0;
        o_firstFailAddr <= '0;
        o_done          <= 1'b0;
        o_pass          <= 1'b0;
        o_timeout       <= 1'b0;
      end
      if (capture) begin
        rd_byte <= i_dataRead;
      end
      if (state == ST_CHECK && mismatch) begin
        if (o_errCount != '1) begin
          o_errCount <= o_errCount + ERR_W'(1);
        end
        if (o_errCount == '0) begin
          o_firstFailAddr <= addr;
        end
      end
      if (state == ST_CHECK && state_nxt == ST_DONE) begin
        o_done <= 1'b1;
        o_pass <= !mismatch && (o_errCount == '0);
      end
      if (state != ST_TMO && state_nxt == ST_TMO) begin
        o_timeout <= 1'b1;
        o_done    <= 1'b1;
        o_pass    <= 1'b0;
      end
    end
  end

  assign o_running = !(state == ST_IDLE || state == ST_DONE || state == ST_TMO);
  assign o_state   = state;

endmodule

// File: tb/tb_psram_bist.sv
// Bench for psram_bist: two instances (window 0x000..0x00F and 0x100..0x103)
// against a randomized-latency PSRAM model with programmable corruption.
module tb_psram_bist;
  import gm64_bist_pkg::*;

  typedef struct packed {
    logic        g;
    logic        wr;
    logic [23:0] addr;
    logic [7:0]  data;
  } txn_t;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst;

  logic [1:0] start;
  logic [1:0] pattern;
  logic       stop_on_err;
  logic       bank;
  logic [1:0] busy;
  logic [1:0] data_ready;
  logic [7:0] rdata [2];

  wire  [1:0]  cs, wr, bank_o, running, done, pass, timeout;
  wire  [23:0] address [2];
  wire  [7:0]  wdata [2];
  wire  [15:0] err_count [2];
  wire  [23:0] first_fail [2];
  BistState    st [2];

  psram_bist #(.START_ADDR(24'h000000), .LENGTH(16)) u_dut0 (
    .clkSys(clk), .rst(rst), .i_start(start[0]), .i_pattern(pattern),
    .i_stopOnErr(stop_on_err), .i_bank(bank), .o_cs(cs[0]), .o_write(wr[0]),
    .o_address(address[0]), .o_bank(bank_o[0]), .o_dataToWrite(wdata[0]),
    .i_dataRead(rdata[0]), .i_busy(busy[0]), .i_dataReady(data_ready[0]),
    .o_running(running[0]), .o_done(done[0]), .o_pass(pass[0]),
    .o_timeout(timeout[0]), .o_errCount(err_count[0]),
    .o_firstFailAddr(first_fail[0]), .o_state(st[0])
  );

  psram_bist #(.START_ADDR(24'h000100), .LENGTH(4)) u_dut1 (
    .clkSys(clk), .rst(rst), .i_start(start[1]), .i_pattern(pattern),
    .i_stopOnErr(stop_on_err), .i_bank(bank), .o_cs(cs[1]), .o_write(wr[1]),
    .o_address(address[1]), .o_bank(bank_o[1]), .o_dataToWrite(wdata[1]),
    .i_dataRead(rdata[1]), .i_busy(busy[1]), .i_dataReady(data_ready[1]),
    .o_running(running[1]), .o_done(done[1]), .o_pass(pass[1]),
    .o_timeout(timeout[1]), .o_errCount(err_count[1]),
    .o_firstFailAddr(first_fail[1]), .o_state(st[1])
  );

  // ---------------- memory model / monitor ----------------
  logic [7:0]  mem [2][512];
  int          lat_cnt [2];
  bit          hung [2];
  bit          pend_rd [2];
  logic [1:0]  prev_cs;
  bit          stuck_mode = 1'b0;
  logic [15:0] corrupt_mask = '0;
  int          cs_double = 0;
  txn_t        obs_q [$];

  always @(negedge clk) begin
    for (int g = 0; g < 2; g++) begin
      if (!rst) begin
        busy[g] = 1'b0; data_ready[g] = 1'b0; lat_cnt[g] = 0;
        hung[g] = 1'b0; pend_rd[g] = 1'b0; prev_cs[g] = 1'b1; rdata[g] = 8'h00;
      end else begin
        data_ready[g] = 1'b0;
        if (hung[g] && !stuck_mode) begin
          hung[g] = 1'b0; busy[g] = 1'b0;
        end
        if (lat_cnt[g] > 0) begin
          lat_cnt[g]--;
          if (lat_cnt[g] == 0 && !hung[g]) begin
            busy[g] = 1'b0; data_ready[g] = pend_rd[g];
          end
        end
        if (cs[g] == 1'b0) begin
          if (prev_cs[g] == 1'b0) cs_double++;
          obs_q.push_back('{g: g[0], wr: wr[g], addr: address[g], data: wdata[g]});
          busy[g] = 1'b1;
          lat_cnt[g] = $urandom_range(1, 4);
          pend_rd[g] = !wr[g];
          if (wr[g]) begin
            mem[g][address[g][8:0]] = wdata[g];
            if (stuck_mode) hung[g] = 1'b1;
          end else if (g == 0 && address[g] < 24'd16 && corrupt_mask[address[g][3:0]]) begin
            rdata[g] = 8'h00;
          end else begin
            rdata[g] = mem[g][address[g][8:0]];
          end
        end
        prev_cs[g] = cs[g];
      end
    end
  end

  // ---------------- scoreboard helpers ----------------
  int n_asserts = 0;
  int n_fail    = 0;

  task automatic check(input string tag, input logic [39:0] obs, input logic [39:0] exp);
    n_asserts++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    end
  endtask

  // Expected byte: pattern rule applied to the address, LFSR = seed stepped idx times
  function automatic logic [7:0] ref_byte(input logic [1:0] pat, input logic [23:0] a, input int idx);
    logic [7:0] l;
    l = 8'hA5;
    for (int k = 0; k < idx; k++) l = l[0] ? ((l >> 1) ^ 8'hB8) : (l >> 1);
    case (pat)
      2'd0:    return 8'hCA;
      2'd1:    return a[7:0];
      2'd2:    return ~a[7:0];
      default: return l;
    endcase
  endfunction

  function automatic int count_reads(input int g, input int base);
    int n;
    n = 0;
    for (int k = base; k < obs_q.size(); k++)
      if (obs_q[k].g == g[0] && !obs_q[k].wr) n++;
    return n;
  endfunction

  task automatic check_reset(input int g, input string tag);
    check({tag, "_cs"}, 40'(cs[g]), 40'd1);
    check({tag, "_write"}, 40'(wr[g]), 40'd0);
    check({tag, "_address"}, 40'(address[g]), 40'd0);
    check({tag, "_bank"}, 40'(bank_o[g]), 40'd0);
    check({tag, "_wdata"}, 40'(wdata[g]), 40'd0);
    check({tag, "_running"}, 40'(running[g]), 40'd0);
    check({tag, "_done"}, 40'(done[g]), 40'd0);
    check({tag, "_pass"}, 40'(pass[g]), 40'd0);
    check({tag, "_timeout"}, 40'(timeout[g]), 40'd0);
    check({tag, "_errcount"}, 40'(err_count[g]), 40'd0);
    check({tag, "_firstfail"}, 40'(first_fail[g]), 40'd0);
    check({tag, "_state"}, 40'(st[g]), 40'(ST_IDLE));
  endtask

  // ---------------- driver tasks ----------------
  task automatic pulse_start(input int g, input logic [1:0] pat, input logic stop, input logic bnk);
    @(negedge clk);
    pattern = pat; stop_on_err = stop; bank = bnk; start[g] = 1'b1;
    @(negedge clk);
    start[g] = 1'b0;
  endtask

  task automatic wait_done(input int g, input int limit, input string tag);
    int n;
    n = 0;
    while (!done[g] && n < limit) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_done_seen"}, 40'(done[g]), 40'd1);
  endtask

  task automatic run_test(input string tag, input int g, input logic [1:0] pat, input logic stop,
                          input logic [15:0] cmask, input bit poke);
    int          base, len, nerr;
    logic [23:0] sa, ff, a;
    logic        bnk, bad;
    txn_t        exp_q [$];
    txn_t        got_q [$];
    txn_t        t;
    sa   = (g == 0) ? 24'h000000 : 24'h000100;
    len  = (g == 0) ? 16 : 4;
    corrupt_mask = (g == 0) ? cmask : 16'h0000;
    bnk  = 1'($urandom_range(0, 1));
    base = obs_q.size();
    pulse_start(g, pat, stop, bnk);
    if (poke) begin
      repeat (20) @(negedge clk);
      pulse_start(g, ~pat, ~stop, ~bnk);
    end
    wait_done(g, 4000, tag);
    repeat (2) @(negedge clk);
    nerr = 0; ff = '0;
    for (int i = 0; i < len; i++) begin
      a = sa + 24'(i);
      exp_q.push_back('{g: g[0], wr: 1'b1, addr: a, data: ref_byte(pat, a, i)});
    end
    for (int i = 0; i < len; i++) begin
      a = sa + 24'(i);
      exp_q.push_back('{g: g[0], wr: 1'b0, addr: a, data: 8'h00});
      bad = (g == 0) && (a < 24'd16) && cmask[a[3:0]] && (ref_byte(pat, a, i) != 8'h00);
      if (bad) begin
        if (nerr == 0) ff = a;
        nerr++;
        if (stop) break;
      end
    end
    for (int k = base; k < obs_q.size(); k++) begin
      if (obs_q[k].g == g[0]) begin
        t = obs_q[k];
        if (!t.wr) t.data = 8'h00;
        got_q.push_back(t);
      end
    end
    check({tag, "_n_strobes"}, 40'(got_q.size()), 40'(exp_q.size()));
    for (int k = 0; k < exp_q.size() && k < got_q.size(); k++)
      check($sformatf("%s_txn%0d", tag, k), 40'(got_q[k]), 40'(exp_q[k]));
    check({tag, "_errcount"}, 40'(err_count[g]), 40'(nerr));
    check({tag, "_firstfail"}, 40'(first_fail[g]), 40'(ff));
    check({tag, "_pass"}, 40'(pass[g]), 40'(nerr == 0));
    check({tag, "_timeout"}, 40'(timeout[g]), 40'd0);
    check({tag, "_running"}, 40'(running[g]), 40'd0);
    check({tag, "_bank"}, 40'(bank_o[g]), 40'(bnk));
    check({tag, "_cs_idle"}, 40'(cs[g]), 40'd1);
    check({tag, "_state"}, 40'(st[g]), 40'(ST_DONE));
    check({tag, "_cs_back_to_back"}, 40'(cs_double), 40'd0);
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    int n, base;
    rst = 1'b0; start = '0; pattern = '0; stop_on_err = 1'b0; bank = 1'b0;
    repeat (3) @(negedge clk);
    check_reset(0, "reset0");
    check_reset(1, "reset1");
    rst = 1'b1;
    repeat (2) @(negedge clk);

    run_test("const_pass", 0, 2'd0, 1'b0, 16'h0000, 1'b0);
    run_test("addr_win100", 1, 2'd1, 1'b0, 16'h0000, 1'b0);
    run_test("naddr_bad5", 0, 2'd2, 1'b0, 16'h0020, 1'b0);
    run_test("naddr_stop5", 0, 2'd2, 1'b1, 16'h0220, 1'b0);
    for (int r = 0; r < 3; r++)
      run_test($sformatf("rand%0d", r), 0, 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
               16'($urandom & $urandom & $urandom), (r == 0));

    // Controller hangs after the first write
    stuck_mode = 1'b1;
    base = obs_q.size();
    pulse_start(0, 2'($urandom_range(0, 3)), 1'b0, 1'b0);
    n = 0;
    while (cs[0] !== 1'b0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    check("tmo_first_strobe", 40'(cs[0]), 40'd0);
    n = 0;
    while (!timeout[0] && n < 2000) begin
      @(negedge clk);
      n++;
    end
    check("tmo_latency", 40'(n), 40'd1023);
    check("tmo_done", 40'(done[0]), 40'd1);
    check("tmo_pass", 40'(pass[0]), 40'd0);
    check("tmo_running", 40'(running[0]), 40'd0);
    check("tmo_state", 40'(st[0]), 40'(ST_TMO));
    repeat (50) @(negedge clk);
    check("tmo_single_strobe", 40'(obs_q.size() - base), 40'd1);
    check("tmo_cs_idle", 40'(cs[0]), 40'd1);
    stuck_mode = 1'b0;
    repeat (2) @(negedge clk);

    run_test("lfsr_pass", 0, 2'd3, 1'b0, 16'h0000, 1'b0);

    // Reset during the read pass
    base = obs_q.size();
    pulse_start(0, 2'd3, 1'b0, 1'b1);
    n = 0;
    while (count_reads(0, base) < 3 && n < 3000) begin
      @(negedge clk);
      n++;
    end
    check("midrst_reads_reached", 40'(count_reads(0, base) >= 3), 40'd1);
    #2 rst = 1'b0;
    #1 check_reset(0, "midrst_async");
    repeat (5) @(negedge clk);
    check_reset(0, "midrst_held");
    rst = 1'b1;
    base = obs_q.size();
    repeat (10) @(negedge clk);
    check("midrst_no_strobes", 40'(obs_q.size() - base), 40'd0);
    base = obs_q.size();
    run_test("after_rst", 0, 2'd3, 1'b0, 16'h0000, 1'b0);
    check("after_rst_first_byte", 40'(obs_q[base].data), 40'h0A5);

    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
    $finish;
  end

endmodule
